// File: rtl/heu_window_rx.sv
// heu_window_rx: receiving end of the IPGU -> HEU window interface.
// A 20x20 pixel window is captured from the IPGU output buffer in one beat
// and is held in local bank storage. It is then streamed to the HEU one
// 20-pixel row per accepted beat.
// Optional feature macro: HEU_RX_DBL_BUF_EN. When it is defined, two ping-pong
// banks are used and the capacity is 2. When it is undefined, there is a
// single bank, and a new capture waits until that bank has been drained.
module heu_window_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int WIN_DIM    = 20
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                vldIpgu,
  input  logic [4:0][79:0][DATA_WIDTH-1:0]    ipguOutBufferQ,
  output logic                                rdyHeu,
  input  logic                                rdyDown,
  output logic                                vldRow,
  output logic [WIN_DIM-1:0][DATA_WIDTH-1:0]  rowData,
  output logic [4:0]                          rowIdx,
  output logic                                lastRow
);

  localparam logic [4:0] LAST_ROW = 5'(WIN_DIM - 1);
`ifdef HEU_RX_DBL_BUF_EN
  localparam logic [1:0] CAPACITY = 2'd2;
`else
  localparam logic [1:0] CAPACITY = 2'd1;
`endif

  typedef logic [WIN_DIM-1:0][WIN_DIM-1:0][DATA_WIDTH-1:0] win_t;
  typedef enum logic {S_IDLE, S_STREAM} state_e;

  state_e     state_q, state_d;
  logic [4:0] rowIdx_q, rowIdx_d;
  logic [1:0] count_q, count_d;
  logic       rdyHeu_q, rdyHeu_d;
  logic       capture, accept, drain;
  win_t       capWin, rdWin;

  // The IPGU buffer is in raster order, with element [i][j] holding byte
  // i*80+j. The window layout is also raster order, with [r][c] holding byte
  // r*20+c. Both layouts therefore line up bit for bit.
  assign capWin = ipguOutBufferQ;

  assign capture = vldIpgu && rdyHeu_q;
  assign vldRow  = (state_q == S_STREAM);
  assign accept  = vldRow && rdyDown;
  assign drain   = accept && (rowIdx_q == LAST_ROW);

`ifdef HEU_RX_DBL_BUF_EN
  logic wrPtr_q, rdPtr_q;
  win_t bank_q [2];

  // Ping-pong pointers: the write side toggles per capture and the read side toggles per drained window
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrPtr_q <= 1'b0;
      rdPtr_q <= 1'b0;
    end else begin
      if (capture) wrPtr_q <= ~wrPtr_q;
      if (drain)   rdPtr_q <= ~rdPtr_q;
    end
  end

  // Bank storage has no reset; the occupancy count alone decides which bank holds a live window
  always_ff @(posedge clk) begin
    if (capture) bank_q[wrPtr_q] <= capWin;
  end

  assign rdWin = bank_q[rdPtr_q];
`else
  win_t bank_q;

  // The single bank is only written while empty, so a presented row is never overwritten
  always_ff @(posedge clk) begin
    if (capture) bank_q <= capWin;
  end

  assign rdWin = bank_q;
`endif

  // Next-state logic: occupancy, row counter, ready, and the read FSM
  always_comb begin
    count_d  = count_q;
    rowIdx_d = rowIdx_q;
    state_d  = state_q;
    rdyHeu_d = 1'b0;

    if (capture && !drain) begin
      count_d = count_q + 2'd1;
    end else if (drain && !capture) begin
      count_d = count_q - 2'd1;
    end

    if (accept) begin
      rowIdx_d = drain ? 5'd0 : rowIdx_q + 5'd1;
    end

    case (state_q)
      S_IDLE: begin
        rowIdx_d = 5'd0;
        if (count_d != 2'd0) state_d = S_STREAM;
      end
      S_STREAM: begin
        if (drain && (count_d == 2'd0)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    rdyHeu_d = (count_d < CAPACITY);
  end

  // State registers; reset discards any stored or partly streamed window
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rowIdx_q <= 5'd0;
      count_q  <= 2'd0;
      rdyHeu_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rowIdx_q <= rowIdx_d;
      count_q  <= count_d;
      rdyHeu_q <= rdyHeu_d;
    end
  end

  assign rdyHeu  = rdyHeu_q;
  assign rowIdx  = rowIdx_q;
  assign lastRow = vldRow && (rowIdx_q == LAST_ROW);
  assign rowData = vldRow ? rdWin[rowIdx_q] : '0;

endmodule

// File: tb/tb_heu_window_rx.sv
// tb_heu_window_rx: randomized self-checking bench for heu_window_rx.
// The reference model is a queue of captured windows plus a current-row
// pointer. Expected row pixels are taken straight from each window's raster
// bytes.
module tb_heu_window_rx;

`ifdef HEU_RX_DBL_BUF_EN
  localparam int CAP      = 2;
  localparam int EXP_GAPS = 0;
`else
  localparam int CAP      = 1;
  localparam int EXP_GAPS = 2;
`endif

  typedef logic [399:0][7:0] rasterT;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 vldIpgu;
  logic [4:0][79:0][7:0] ipguOutBufferQ;
  logic                 rdyHeu;
  logic                 rdyDown;
  logic                 vldRow;
  logic [19:0][7:0]     rowData;
  logic [4:0]           rowIdx;
  logic                 lastRow;

  rasterT curWin;
  rasterT winQ[$];
  int     curRow;
  logic   expRdy;
  bit     captured;
  int     checkCount;
  int     failCount;

  heu_window_rx #(.DATA_WIDTH(8), .WIN_DIM(20)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .vldIpgu        (vldIpgu),
    .ipguOutBufferQ (ipguOutBufferQ),
    .rdyHeu         (rdyHeu),
    .rdyDown        (rdyDown),
    .vldRow         (vldRow),
    .rowData        (rowData),
    .rowIdx         (rowIdx),
    .lastRow        (lastRow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checkCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Load a new window: either the ramp pattern k%256 or random bytes
  task automatic loadWindow(input bit ramp);
    for (int k = 0; k < 400; k++) curWin[k] = ramp ? 8'(k) : 8'($urandom);
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 80; j++)
        ipguOutBufferQ[i][j] = curWin[i*80 + j];
  endtask

  // Advance one clock, update the reference model, and compare every output
  task automatic applyStimulus();
    logic         cap, acc, expVld, expLast;
    logic [4:0]   expIdx;
    logic [159:0] expData;
    cap = rst_n && vldIpgu && expRdy;
    acc = rst_n && (winQ.size() != 0) && rdyDown;
    @(posedge clk);
    if (!rst_n) begin
      winQ.delete();
      curRow = 0;
      expRdy = 1'b0;
    end else begin
      if (acc) begin
        if (curRow == 19) begin
          winQ.delete(0);
          curRow = 0;
        end else begin
          curRow++;
        end
      end
      if (cap) winQ.push_back(curWin);
      expRdy = (winQ.size() < CAP);
    end
    captured = cap;
    #1;
    expVld  = (winQ.size() != 0);
    expIdx  = 5'(curRow);
    expLast = expVld && (curRow == 19);
    expData = '0;
    if (expVld)
      for (int c = 0; c < 20; c++) expData[c*8 +: 8] = winQ[0][curRow*20 + c];
    checkOutput("vldRow",  160'(vldRow),  160'(expVld));
    checkOutput("rdyHeu",  160'(rdyHeu),  160'(expRdy));
    checkOutput("rowIdx",  160'(rowIdx),  160'(expIdx));
    checkOutput("lastRow", 160'(lastRow), 160'(expLast));
    checkOutput("rowData", 160'(rowData), expData);
  endtask

  // Let every pending window drain completely with rdyDown held high
  task automatic drainAll(input string tag);
    bit done;
    done = 1'b0;
    rdyDown = 1'b1;
    for (int n = 0; n < 300; n++) begin
      if (winQ.size() == 0 && !vldIpgu) begin
        done = 1'b1;
        break;
      end
      applyStimulus();
      if (captured) vldIpgu = 1'b0;
    end
    checkOutput(tag, 160'(done), 160'(1));
  endtask

  initial begin
    int  sent, beats, gaps, lasts;
    bit  started, reached;
    checkCount = 0;
    failCount  = 0;
    expRdy     = 1'b0;
    curRow     = 0;
    rst_n      = 1'b0;
    vldIpgu    = 1'b0;
    rdyDown    = 1'b0;
    loadWindow(1'b1);

    // Reset, then a single ramp window
    repeat (3) applyStimulus();
    checkOutput("rst_rdy", 160'(rdyHeu), 160'(0));
    checkOutput("rst_vld", 160'(vldRow), 160'(0));
    rst_n = 1'b1;
    applyStimulus();
    checkOutput("rdy_after_rst", 160'(rdyHeu), 160'(1));
    vldIpgu = 1'b1;
    rdyDown = 1'b1;
    applyStimulus();
    vldIpgu = 1'b0;
    checkOutput("first_row_vld", 160'(vldRow), 160'(1));
    checkOutput("first_row_px5", 160'(rowData[5]), 160'(5));
    drainAll("drain_single");

    // Backpressure: rdyDown cycles through 1,0,0
    loadWindow(1'b0);
    vldIpgu = 1'b1;
    for (int n = 0; n < 80; n++) begin
      rdyDown = (n % 3 == 0);
      applyStimulus();
      if (captured) vldIpgu = 1'b0;
    end
    drainAll("drain_bp");

    // Back to back: three windows with vldIpgu held high
    sent = 0; beats = 0; gaps = 0; lasts = 0; started = 1'b0;
    loadWindow(1'b0);
    vldIpgu = 1'b1;
    rdyDown = 1'b1;
    for (int n = 0; n < 200 && beats < 60; n++) begin
      applyStimulus();
      if (vldRow) begin
        started = 1'b1;
        beats++;
        if (lastRow) lasts++;
      end else if (started) begin
        gaps++;
      end
      if (captured) begin
        sent++;
        if (sent < 3) loadWindow(1'b0);
        else vldIpgu = 1'b0;
      end
    end
    checkOutput("b2b_beats", 160'(beats), 160'(60));
    checkOutput("b2b_gaps",  160'(gaps),  160'(EXP_GAPS));
    checkOutput("b2b_lasts", 160'(lasts), 160'(3));
    drainAll("drain_b2b");

    // Offer a new window on the same edge that row 19 is accepted
    loadWindow(1'b0);
    vldIpgu = 1'b1;
    rdyDown = 1'b1;
    reached = 1'b0;
    for (int n = 0; n < 60; n++) begin
      applyStimulus();
      if (captured) vldIpgu = 1'b0;
      if (winQ.size() != 0 && curRow == 19) begin
        reached = 1'b1;
        break;
      end
    end
    checkOutput("sim_reach", 160'(reached), 160'(1));
    loadWindow(1'b0);
    vldIpgu = 1'b1;
    applyStimulus();
    if (captured) vldIpgu = 1'b0;
    drainAll("drain_sim");

    // Reset while row 7 is presented and a second window is stored
    sent = 0;
    reached = 1'b0;
    loadWindow(1'b0);
    vldIpgu = 1'b1;
    rdyDown = 1'b1;
    for (int n = 0; n < 60; n++) begin
      applyStimulus();
      if (captured) begin
        sent++;
        if (sent < 2) loadWindow(1'b0);
        else vldIpgu = 1'b0;
      end
      if (winQ.size() != 0 && curRow == 7) begin
        reached = 1'b1;
        break;
      end
    end
    checkOutput("midrst_reach", 160'(reached), 160'(1));
    vldIpgu = 1'b0;
    rst_n = 1'b0;
    applyStimulus();
    checkOutput("midrst_vld", 160'(vldRow), 160'(0));
    checkOutput("midrst_rdy", 160'(rdyHeu), 160'(0));
    rst_n = 1'b1;
    applyStimulus();
    checkOutput("midrst_rdy1", 160'(rdyHeu), 160'(1));
    repeat (8) applyStimulus();

    // Random traffic on both sides of the interface
    for (int n = 0; n < 600; n++) begin
      if (!vldIpgu && $urandom_range(0, 3) == 0) begin
        loadWindow(1'b0);
        vldIpgu = 1'b1;
      end
      rdyDown = ($urandom_range(0, 3) != 0);
      applyStimulus();
      if (captured) vldIpgu = 1'b0;
    end
    drainAll("drain_rand");

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
